mcp300x_scan: RTL



---
 rtl/mcp300x_pkg.sv | 36 +++
 rtl/spi_clk_div.sv | 53 +++++
 rtl/mcp300x_scan.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mcp300x_pkg.sv
// Shared types and helpers for the MCP300x channel scanner.
package mcp300x_pkg;

    // SCLK periods per conversion frame.
    localparam int FRAME_BITS = 24;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } scan_state_t;

    // Position of the command start bit. It is chosen so that the last
    // ADC_BITS of the 24 clocks carry the conversion result.
    function automatic int start_bit_idx(input int adc_bits);
        return 17 - adc_bits;
    endfunction

    // MOSI value for frame bit k: start, SGL/DIFF, D2, D1, D0, otherwise 0.
    function automatic logic frame_bit(input int k, input int adc_bits,
                                       input logic [2:0] ch, input logic diff);
        int   s;
        logic b;
        s = start_bit_idx(adc_bits);
        b = 1'b0;
        if (k == s)          b = 1'b1;
        else if (k == s + 1) b = ~diff;
        else if (k == s + 2) b = ch[2];
        else if (k == s + 3) b = ch[1];
        else if (k == s + 4) b = ch[0];
        return b;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator and registered SPI mode-0 clock.
// While run_i is low SCLK is parked low; the counter is cleared whenever
// en_i is low so every frame sequence starts on a fresh half-period.
module spi_clk_div #(
    parameter int CLK_DIV = 64
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic run_i,
    output logic tick_o,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign rise_o = tick_o && run_i && !sclk_q;
    assign fall_o = tick_o && run_i && sclk_q;
    assign sclk_o = sclk_q;

    // Next divider count and SCLK level.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick_o) begin
            cnt_d  = '0;
            sclk_d = run_i ? ~sclk_q : 1'b0;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    // Divider and SCLK registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/mcp300x_scan.sv
// Scanner for MCP3008/MCP3208-style SPI ADCs: converts every enabled
// channel in ascending order, one 24-clock frame per channel.
//
// Handshake: start is a one-cycle request, accepted only in IDLE with a
// non-zero chan_en; busy rises the cycle after acceptance and falls on the
// return to IDLE. sample_valid/scan_done are one-cycle pulses with no
// back-pressure; adc_out and sample_chan are valid while sample_valid is 1.
module mcp300x_scan
    import mcp300x_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADC_BITS = 10,
    parameter int CLK_DIV  = 64,
    parameter int CS_GAP   = 2
) (
    input  logic                       CLK50,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       continuous,
    input  logic                       diff_mode,
    input  logic [NUM_CH-1:0]          chan_en,
    input  logic                       SPI_IN,
    output logic                       SPI_OUT,
    output logic                       SCLK,
    output logic                       CS_n,
    output logic [NUM_CH*ADC_BITS-1:0] adc_out,
    output logic                       sample_valid,
    output logic [2:0]                 sample_chan,
    output logic                       scan_done,
    output logic                       busy
);

    localparam logic [15:0] LAST_HP  = 16'(2 * FRAME_BITS - 1);
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    scan_state_t         state_q, state_d;
    logic [15:0]         hp_q, hp_d;
    logic [2:0]          ch_q;
    logic [NUM_CH-1:0]   mask_q;
    logic                diff_q;
    logic [ADC_BITS-1:0] shreg_q;
    logic                mosi_q, mosi_d;
    logic [ADC_BITS-1:0] res_q [NUM_CH];
    logic                sample_valid_q, scan_done_q;
    logic [2:0]          sample_chan_q;

    logic                div_en, sclk_run, tick, rise, fall;
    logic                has_next;
    logic [2:0]          next_ch, first_new;
    logic                accept, gap_end, setup_entry;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk_i   (CLK50),
        .reset_i (reset),
        .en_i    (div_en),
        .run_i   (sclk_run),
        .tick_o  (tick),
        .sclk_o  (SCLK),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    // Channel search: next enabled channel above the current one, and the
    // lowest channel of a freshly latched mask.
    always_comb begin
        has_next  = 1'b0;
        next_ch   = ch_q;
        first_new = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ch_q))) begin
                has_next = 1'b1;
                next_ch  = 3'(i);
            end
            if (chan_en[i]) begin
                first_new = 3'(i);
            end
        end
    end

    assign accept      = (state_q == IDLE) && (state_d == SETUP);
    assign gap_end     = (state_q == GAP) && tick && (hp_q == GAP_LAST);
    assign setup_entry = (state_d == SETUP) && (state_q != SETUP);

    // FSM state register.
    always_ff @(posedge CLK50) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic; every timed step advances on a half-period tick.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (start && (chan_en != '0))      state_d = SETUP;
            SETUP: if (tick)                          state_d = SHIFT;
            SHIFT: if (tick && (hp_q == LAST_HP))     state_d = HOLD;
            HOLD:  if (tick)                          state_d = GAP;
            GAP: begin
                if (gap_end) begin
                    if (has_next || (continuous && (chan_en != '0))) state_d = SETUP;
                    else                                             state_d = IDLE;
                end
            end
            default:                                  state_d = IDLE;
        endcase
    end

    // FSM outputs decoded from the state register.
    always_comb begin
        CS_n     = 1'b1;
        busy     = 1'b1;
        div_en   = 1'b1;
        sclk_run = 1'b0;
        case (state_q)
            IDLE: begin
                busy   = 1'b0;
                div_en = 1'b0;
            end
            SETUP:   CS_n = 1'b0;
            SHIFT: begin
                CS_n     = 1'b0;
                sclk_run = 1'b1;
            end
            HOLD:    CS_n = 1'b0;
            GAP:     CS_n = 1'b1;
            default: CS_n = 1'b1;
        endcase
    end

    // Half-period counter (restarts on every state change) and MOSI, which
    // only moves on the SETUP->SHIFT step or a falling SCLK edge.
    always_comb begin
        hp_d = hp_q;
        if (state_d != state_q) hp_d = '0;
        else if (tick)          hp_d = hp_q + 16'd1;

        mosi_d = mosi_q;
        if ((state_q == SETUP) && tick)
            mosi_d = frame_bit(0, ADC_BITS, ch_q, diff_q);
        else if (fall)
            mosi_d = (hp_q == LAST_HP) ? 1'b0
                   : frame_bit(int'(hp_q[5:1]) + 1, ADC_BITS, ch_q, diff_q);
        else if (state_q != SHIFT)
            mosi_d = 1'b0;
    end

    // Frame sequencing registers: counter, MOSI, latched mask/channel/mode.
    always_ff @(posedge CLK50) begin
        if (reset) begin
            hp_q   <= '0;
            mosi_q <= 1'b0;
            mask_q <= '0;
            ch_q   <= 3'd0;
            diff_q <= 1'b0;
        end else begin
            hp_q   <= hp_d;
            mosi_q <= mosi_d;
            if (accept) begin
                mask_q <= chan_en;
                ch_q   <= first_new;
            end else if (gap_end) begin
                if (has_next) begin
                    ch_q <= next_ch;
                end else begin
                    mask_q <= chan_en;
                    ch_q   <= first_new;
                end
            end
            if (setup_entry) diff_q <= diff_mode;
        end
    end

    // MISO capture on SCLK rising edges and result publication at HOLD end.
    always_ff @(posedge CLK50) begin
        if (reset) begin
            shreg_q        <= '0;
            sample_valid_q <= 1'b0;
            sample_chan_q  <= 3'd0;
            scan_done_q    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) res_q[i] <= '0;
        end else begin
            sample_valid_q <= 1'b0;
            scan_done_q    <= 1'b0;
            if (rise) shreg_q <= {shreg_q[ADC_BITS-2:0], SPI_IN};
            if ((state_q == HOLD) && tick) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_q == 3'(i)) res_q[i] <= shreg_q;
                end
                sample_valid_q <= 1'b1;
                sample_chan_q  <= ch_q;
                scan_done_q    <= ~has_next;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign adc_out[g*ADC_BITS +: ADC_BITS] = res_q[g];
    end

    assign SPI_OUT      = mosi_q;
    assign sample_valid = sample_valid_q;
    assign sample_chan  = sample_chan_q;
    assign scan_done    = scan_done_q;

endmodule
